// File: rtl/processor.sv
// processor: single-cycle RV32I-subset core.
// One instruction per clock: fetch from a combinational instruction memory,
// decode, execute, and commit PC / register file / data-memory write on the
// same rising edge of i_clk. i_reset is asynchronous and active low.
//
// Optional build macro:
//   PROC_MUL_EN - when defined, R-type funct7=0000001/funct3=000 executes as
//                 mul (low 32 bits of rs1*rs2). When undefined, that encoding
//                 is unsupported and retires as a NOP.
//
// Memory interface semantics: there is no stall/handshake. o_write_enable is
// a single-cycle strobe, valid for the whole cycle in which a store executes,
// and the data memory commits o_data_to_mem at o_address_to_mem on the
// rising edge that ends that cycle. i_data_from_mem must be a combinational
// function of o_address_to_mem within the same cycle.

module processor #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic [31:0] o_pc,
   input  logic [31:0] i_instruction,
   output logic        o_write_enable,
   output logic [31:0] o_address_to_mem,
   output logic [31:0] o_data_to_mem,
   input  logic [31:0] i_data_from_mem
);

   // Major opcodes of the supported subset
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLT,
      ALU_SLTU,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_MUL,
      ALU_PASS_B
   } alu_op_t;

   typedef enum logic [1:0] {
      WB_ALU,
      WB_MEM,
      WB_PC4
   } wb_sel_t;

   // Architectural state
   logic [31:0] pc;
   logic [31:0] regs [32];

   // Instruction fields
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;

   // Sign-extended immediates for every format
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   // Decoded control
   alu_op_t     alu_op;
   wb_sel_t     wb_sel;
   logic [31:0] op_imm;
   logic        src_a_pc;
   logic        src_b_imm;
   logic        reg_write;
   logic        mem_write;
   logic        is_branch;
   logic        is_jal;
   logic        is_jalr;

   // Datapath
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic [4:0]  shamt;
   logic        branch_taken;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic [31:0] wb_data;

   assign opcode = i_instruction[6:0];
   assign rd     = i_instruction[11:7];
   assign funct3 = i_instruction[14:12];
   assign rs1    = i_instruction[19:15];
   assign rs2    = i_instruction[24:20];
   assign funct7 = i_instruction[31:25];

   assign imm_i = {{20{i_instruction[31]}}, i_instruction[31:20]};
   assign imm_s = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
   assign imm_b = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                   i_instruction[30:25], i_instruction[11:8], 1'b0};
   assign imm_u = {i_instruction[31:12], 12'b0};
   assign imm_j = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                   i_instruction[20], i_instruction[30:21], 1'b0};

   // Register reads: x0 is hard-wired to zero. Reads see the pre-edge value,
   // which is exactly what a single-cycle core needs.
   assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

   // Decode: anything not explicitly recognised leaves every write disabled
   // and the PC on its default +4 path, so illegal words retire as NOPs.
   always_comb begin
      alu_op    = ALU_ADD;
      wb_sel    = WB_ALU;
      op_imm    = imm_i;
      src_a_pc  = 1'b0;
      src_b_imm = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;

      case (opcode)
         OP_R: begin
            case ({funct7, funct3})
               {F7_BASE, 3'b000}: begin alu_op = ALU_ADD;  reg_write = 1'b1; end
               {F7_ALT,  3'b000}: begin alu_op = ALU_SUB;  reg_write = 1'b1; end
               {F7_BASE, 3'b001}: begin alu_op = ALU_SLL;  reg_write = 1'b1; end
               {F7_BASE, 3'b010}: begin alu_op = ALU_SLT;  reg_write = 1'b1; end
               {F7_BASE, 3'b011}: begin alu_op = ALU_SLTU; reg_write = 1'b1; end
               {F7_BASE, 3'b100}: begin alu_op = ALU_XOR;  reg_write = 1'b1; end
               {F7_BASE, 3'b101}: begin alu_op = ALU_SRL;  reg_write = 1'b1; end
               {F7_ALT,  3'b101}: begin alu_op = ALU_SRA;  reg_write = 1'b1; end
               {F7_BASE, 3'b110}: begin alu_op = ALU_OR;   reg_write = 1'b1; end
               {F7_BASE, 3'b111}: begin alu_op = ALU_AND;  reg_write = 1'b1; end
`ifdef PROC_MUL_EN
               {F7_MULDIV, 3'b000}: begin alu_op = ALU_MUL; reg_write = 1'b1; end
`endif
               default: ;
            endcase
         end

         OP_IMM: begin
            src_b_imm = 1'b1;
            op_imm    = imm_i;
            case (funct3)
               3'b000: begin alu_op = ALU_ADD;  reg_write = 1'b1; end
               3'b010: begin alu_op = ALU_SLT;  reg_write = 1'b1; end
               3'b011: begin alu_op = ALU_SLTU; reg_write = 1'b1; end
               3'b100: begin alu_op = ALU_XOR;  reg_write = 1'b1; end
               3'b110: begin alu_op = ALU_OR;   reg_write = 1'b1; end
               3'b111: begin alu_op = ALU_AND;  reg_write = 1'b1; end
               3'b001: begin
                  if (funct7 == F7_BASE) begin
                     alu_op    = ALU_SLL;
                     reg_write = 1'b1;
                  end
               end
               3'b101: begin
                  if (funct7 == F7_BASE) begin
                     alu_op    = ALU_SRL;
                     reg_write = 1'b1;
                  end else if (funct7 == F7_ALT) begin
                     alu_op    = ALU_SRA;
                     reg_write = 1'b1;
                  end
               end
               default: ;
            endcase
         end

         OP_LOAD: begin
            if (funct3 == 3'b010) begin
               src_b_imm = 1'b1;
               op_imm    = imm_i;
               wb_sel    = WB_MEM;
               reg_write = 1'b1;
            end
         end

         OP_STORE: begin
            if (funct3 == 3'b010) begin
               src_b_imm = 1'b1;
               op_imm    = imm_s;
               mem_write = 1'b1;
            end
         end

         OP_BRANCH: begin
            // funct3 010/011 are reserved branch encodings
            if (funct3 != 3'b010 && funct3 != 3'b011) begin
               is_branch = 1'b1;
            end
         end

         OP_LUI: begin
            alu_op    = ALU_PASS_B;
            src_b_imm = 1'b1;
            op_imm    = imm_u;
            reg_write = 1'b1;
         end

         OP_AUIPC: begin
            src_a_pc  = 1'b1;
            src_b_imm = 1'b1;
            op_imm    = imm_u;
            reg_write = 1'b1;
         end

         OP_JAL: begin
            is_jal    = 1'b1;
            wb_sel    = WB_PC4;
            reg_write = 1'b1;
         end

         OP_JALR: begin
            if (funct3 == 3'b000) begin
               is_jalr   = 1'b1;
               src_b_imm = 1'b1;
               op_imm    = imm_i;
               wb_sel    = WB_PC4;
               reg_write = 1'b1;
            end
         end

         default: ;
      endcase
   end

   assign alu_a = src_a_pc  ? pc     : rs1_val;
   assign alu_b = src_b_imm ? op_imm : rs2_val;
   assign shamt = alu_b[4:0];

   // ALU: 32-bit modulo arithmetic, shift amount from the low five bits of B
   always_comb begin
      alu_result = 32'd0;
      case (alu_op)
         ALU_ADD:    alu_result = alu_a + alu_b;
         ALU_SUB:    alu_result = alu_a - alu_b;
         ALU_AND:    alu_result = alu_a & alu_b;
         ALU_OR:     alu_result = alu_a | alu_b;
         ALU_XOR:    alu_result = alu_a ^ alu_b;
         ALU_SLT:    alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU:   alu_result = {31'd0, alu_a < alu_b};
         ALU_SLL:    alu_result = alu_a << shamt;
         ALU_SRL:    alu_result = alu_a >> shamt;
         ALU_SRA:    alu_result = $unsigned($signed(alu_a) >>> shamt);
`ifdef PROC_MUL_EN
         ALU_MUL:    alu_result = alu_a * alu_b;
`endif
         ALU_PASS_B: alu_result = alu_b;
         default:    alu_result = 32'd0;
      endcase
   end

   // Branch condition evaluated on the raw register operands
   always_comb begin
      branch_taken = 1'b0;
      case (funct3)
         3'b000:  branch_taken = (rs1_val == rs2_val);
         3'b001:  branch_taken = (rs1_val != rs2_val);
         3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
         3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
         3'b110:  branch_taken = (rs1_val <  rs2_val);
         3'b111:  branch_taken = (rs1_val >= rs2_val);
         default: branch_taken = 1'b0;
      endcase
   end

   assign pc_plus4 = pc + 32'd4;

   // Next-PC selection; all sums wrap modulo 2^32
   always_comb begin
      next_pc = pc_plus4;
      if (is_jal) begin
         next_pc = pc + imm_j;
      end else if (is_jalr) begin
         next_pc = {alu_result[31:1], 1'b0};
      end else if (is_branch && branch_taken) begin
         next_pc = pc + imm_b;
      end
   end

   // Write-back source selection
   always_comb begin
      wb_data = alu_result;
      case (wb_sel)
         WB_ALU:  wb_data = alu_result;
         WB_MEM:  wb_data = i_data_from_mem;
         WB_PC4:  wb_data = pc_plus4;
         default: wb_data = alu_result;
      endcase
   end

   // Program counter: loads RESET_PC while reset is held
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= next_pc;
      end
   end

   // Register file: cleared by reset, writes to x0 dropped
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'd0;
         end
      end else if (reg_write && (rd != 5'd0)) begin
         regs[rd] <= wb_data;
      end
   end

   // The store strobe is gated by reset so an in-flight store is discarded
   assign o_write_enable   = mem_write & i_reset;
   assign o_pc             = pc;
   assign o_address_to_mem = alu_result;
   assign o_data_to_mem    = rs2_val;

endmodule

// File: tb/tb_processor.sv
// tb_processor: directed-program bench for processor.
// Each program is loaded into a behavioural instruction memory, expected
// stores are queued, and a monitor compares every store the core issues.

module tb_processor;

   logic        i_clk;
   logic        i_reset;
   logic [31:0] o_pc;
   logic [31:0] i_instruction;
   logic        o_write_enable;
   logic [31:0] o_address_to_mem;
   logic [31:0] o_data_to_mem;
   logic [31:0] i_data_from_mem;

   localparam logic [31:0] HALT = 32'h0000_006F;  // jal x0, 0

   logic [31:0] imem [64];
   logic [31:0] dmem [64];
   logic [31:0] pc_trace [64];
   logic [63:0] exp_q [$];

   int n_compared;
   int n_mismatched;
   int pc_i;

   processor #(.RESET_PC(32'h0000_0000)) dut (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .o_pc             (o_pc),
      .i_instruction    (i_instruction),
      .o_write_enable   (o_write_enable),
      .o_address_to_mem (o_address_to_mem),
      .o_data_to_mem    (o_data_to_mem),
      .i_data_from_mem  (i_data_from_mem)
   );

   // ---------------- clock / reset ----------------
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- memories ----------------
   assign i_instruction   = imem[o_pc[7:2]];
   assign i_data_from_mem = dmem[o_address_to_mem[7:2]];

   always @(posedge i_clk) begin
      if (o_write_enable) dmem[o_address_to_mem[7:2]] <= o_data_to_mem;
   end

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                         input logic [2:0] f3, input int rd);
      return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                         input int rd, input logic [6:0] op);
      logic [31:0] v;
      v = imm;
      return {v[11:0], rs1[4:0], f3, rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
      logic [31:0] v;
      v = imm;
      return {v[11:5], rs2[4:0], rs1[4:0], 3'b010, v[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                         input logic [2:0] f3);
      logic [31:0] v;
      v = imm;
      return {v[12], v[10:5], rs2[4:0], rs1[4:0], f3, v[4:1], v[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
      logic [31:0] v;
      v = imm20;
      return {v[19:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input int rd);
      logic [31:0] v;
      v = imm;
      return {v[20], v[10:1], v[11], v[19:12], rd[4:0], 7'b1101111};
   endfunction

   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_prog();
      for (int i = 0; i < 64; i++) imem[i] = HALT;
      pc_i = 0;
   endtask

   task automatic emit(input logic [31:0] instr);
      imem[pc_i] = instr;
      pc_i++;
   endtask

   task automatic expect_store(input logic [31:0] addr, input logic [31:0] data);
      exp_q.push_back({addr, data});
   endtask

   // Reset, release just after a rising edge, record PC at each falling edge
   task automatic run_prog(input int n);
      i_reset = 1'b0;
      repeat (2) @(posedge i_clk);
      #2 i_reset = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(negedge i_clk);
         pc_trace[k] = o_pc;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic end_test(input string name);
      n_compared++;
      if (exp_q.size() != 0) begin
         n_mismatched++;
         $display("FAIL %s_missing_stores: got %0d pending, expected 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   // Monitor: every store the core issues must match the head of the queue
   always @(negedge i_clk) begin
      logic [63:0] e;
      if (i_reset && o_write_enable) begin
         if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL unexpected_store: got addr %h data %h, expected no store",
                     o_address_to_mem, o_data_to_mem);
         end else begin
            e = exp_q.pop_front();
            check("store", {o_address_to_mem, o_data_to_mem}, e);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int          st_regs [14];
      logic [31:0] st_vals [14];
      logic [31:0] saved;

      n_compared   = 0;
      n_mismatched = 0;
      i_reset      = 1'b0;
      for (int i = 0; i < 64; i++) dmem[i] = 32'd0;

      // ---- ALU ----
      clear_prog();
      emit(addi(1, 0, 5));
      emit(addi(2, 0, -3));
      emit(enc_r(7'h00, 2, 1, 3'b000, 3));    // add  x3,x1,x2
      emit(enc_r(7'h20, 1, 2, 3'b000, 4));    // sub  x4,x2,x1
      emit(enc_r(7'h00, 1, 2, 3'b010, 5));    // slt  x5,x2,x1
      emit(enc_r(7'h20, 1, 2, 3'b101, 6));    // sra  x6,x2,x1
      emit(enc_r(7'h00, 2, 1, 3'b111, 9));    // and  x9,x1,x2
      emit(enc_r(7'h00, 2, 1, 3'b110, 10));   // or   x10,x1,x2
      emit(enc_r(7'h00, 2, 1, 3'b100, 11));   // xor  x11,x1,x2
      emit(enc_r(7'h00, 1, 2, 3'b011, 12));   // sltu x12,x2,x1
      emit(enc_r(7'h00, 1, 2, 3'b101, 13));   // srl  x13,x2,x1
      emit(enc_r(7'h00, 1, 1, 3'b001, 14));   // sll  x14,x1,x1
      emit(enc_i(-1, 1, 3'b100, 15, 7'b0010011));      // xori  x15,x1,-1
      emit(enc_i(3, 1, 3'b001, 16, 7'b0010011));       // slli  x16,x1,3
      emit(enc_i(32'h401, 2, 3'b101, 17, 7'b0010011)); // srai  x17,x2,1
      emit(enc_i(-1, 1, 3'b011, 18, 7'b0010011));      // sltiu x18,x1,-1
      st_regs = '{3, 4, 5, 6, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18};
      st_vals = '{32'h2, 32'hFFFF_FFF8, 32'h1, 32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFD,
                  32'hFFFF_FFF8, 32'h0, 32'h07FF_FFFF, 32'hA0, 32'hFFFF_FFFA,
                  32'h28, 32'hFFFF_FFFE, 32'h1};
      for (int j = 0; j < 14; j++) begin
         emit(enc_s(4 * j, st_regs[j], 0));
         expect_store(4 * j, st_vals[j]);
      end
      run_prog(40);
      end_test("alu");

      // ---- memory ----
      clear_prog();
      emit(enc_u(32'h12345, 7, 7'b0110111));          // lui x7,0x12345
      emit(addi(7, 7, 32'h678));
      emit(enc_s(8, 7, 0));                           // sw x7,8(x0)
      emit(enc_i(8, 0, 3'b010, 8, 7'b0000011));       // lw x8,8(x0)
      emit(enc_s(12, 8, 0));                          // sw x8,12(x0)
      expect_store(32'd8, 32'h1234_5678);
      expect_store(32'd12, 32'h1234_5678);
      run_prog(12);
      end_test("mem");
      check("dmem_word3", {32'd0, dmem[3]}, {32'd0, 32'h1234_5678});

      // ---- branches ----
      clear_prog();
      emit(addi(1, 0, 1));                            // 0x00
      emit(addi(2, 0, 1));                            // 0x04
      emit(enc_b(8, 2, 1, 3'b000));                   // 0x08 beq taken -> 0x10
      emit(enc_s(60, 1, 0));                          // 0x0C poison
      emit(enc_b(8, 2, 1, 3'b001));                   // 0x10 bne not taken
      emit(addi(3, 0, -1));                           // 0x14
      emit(enc_b(8, 1, 3, 3'b100));                   // 0x18 blt -1<1 taken -> 0x20
      emit(enc_s(60, 1, 0));                          // 0x1C poison
      emit(enc_b(8, 1, 3, 3'b110));                   // 0x20 bltu not taken
      emit(enc_s(16, 3, 0));                          // 0x24 sw x3,16
      emit(addi(4, 0, 0));                            // 0x28
      emit(addi(5, 0, 10));                           // 0x2C
      emit(addi(4, 4, 1));                            // 0x30 loop body
      emit(enc_b(-4, 5, 4, 3'b100));                  // 0x34 blt x4,x5 -> 0x30
      emit(enc_s(20, 4, 0));                          // 0x38 sw x4,20
      emit(enc_b(8, 5, 4, 3'b101));                   // 0x3C bge taken -> 0x44
      emit(enc_s(60, 1, 0));                          // 0x40 poison
      emit(enc_b(8, 1, 3, 3'b111));                   // 0x44 bgeu taken -> 0x4C
      emit(enc_s(60, 1, 0));                          // 0x48 poison
      emit(enc_s(24, 5, 0));                          // 0x4C sw x5,24
      expect_store(32'd16, 32'hFFFF_FFFF);
      expect_store(32'd20, 32'd10);
      expect_store(32'd24, 32'd10);
      run_prog(40);
      end_test("branch");
      check("pc_after_beq",   {32'd0, pc_trace[3]},  {32'd0, 32'h10});
      check("pc_after_blt",   {32'd0, pc_trace[6]},  {32'd0, 32'h20});
      check("pc_after_bltu",  {32'd0, pc_trace[7]},  {32'd0, 32'h24});
      check("pc_loop_back",   {32'd0, pc_trace[12]}, {32'd0, 32'h30});
      check("pc_loop_exit",   {32'd0, pc_trace[30]}, {32'd0, 32'h38});
      check("pc_after_bgeu",  {32'd0, pc_trace[33]}, {32'd0, 32'h4C});

      // ---- jumps and x0 ----
      clear_prog();
      repeat (4) emit(addi(0, 0, 0));                 // 0x00..0x0C
      emit(enc_j(8, 1));                              // 0x10 jal x1,+8
      emit(enc_j(12, 0));                             // 0x14 jal x0,+12 -> 0x20
      emit(enc_i(0, 1, 3'b000, 0, 7'b1100111));       // 0x18 jalr x0,0(x1)
      emit(enc_s(60, 1, 0));                          // 0x1C poison
      emit(addi(0, 0, 7));                            // 0x20 addi x0,x0,7
      emit(enc_s(32, 0, 0));                          // 0x24 sw x0,32
      emit(enc_s(36, 1, 0));                          // 0x28 sw x1,36
      emit(addi(2, 0, 32'h3D));                       // 0x2C
      emit(enc_i(0, 2, 3'b000, 3, 7'b1100111));       // 0x30 jalr x3,0(x2) -> 0x3C
      emit(enc_s(60, 1, 0));                          // 0x34 poison
      emit(enc_s(60, 1, 0));                          // 0x38 poison
      emit(enc_s(40, 3, 0));                          // 0x3C sw x3,40
      expect_store(32'd32, 32'd0);
      expect_store(32'd36, 32'h14);
      expect_store(32'd40, 32'h34);
      run_prog(20);
      end_test("jump");
      check("pc_at_jal",  {32'd0, pc_trace[4]}, {32'd0, 32'h10});
      check("pc_at_jalr", {32'd0, pc_trace[5]}, {32'd0, 32'h18});
      check("pc_return",  {32'd0, pc_trace[6]}, {32'd0, 32'h14});
      check("pc_fwd_jal", {32'd0, pc_trace[7]}, {32'd0, 32'h20});

      // ---- mul and illegal encodings ----
      clear_prog();
      emit(addi(1, 0, 7));
      emit(addi(2, 0, -6));
      emit(addi(3, 0, 32'h55));
      emit(enc_r(7'h01, 2, 1, 3'b000, 3));            // mul x3,x1,x2
      emit(enc_s(44, 3, 0));                          // 0x10 sw x3,44
      emit(32'h0000_0000);                            // 0x14 illegal
      emit(32'hFFFF_FFFF);                            // 0x18 illegal, rd field = x31
      emit(enc_s(48, 31, 0));                         // 0x1C sw x31,48
`ifdef PROC_MUL_EN
      expect_store(32'd44, 32'hFFFF_FFD6);
`else
      expect_store(32'd44, 32'h55);
`endif
      expect_store(32'd48, 32'd0);
      run_prog(12);
      end_test("mul_illegal");
      check("pc_after_zero_word", {32'd0, pc_trace[6]}, {32'd0, 32'h18});
      check("pc_after_ones_word", {32'd0, pc_trace[7]}, {32'd0, 32'h1C});

      // ---- reset: PC and store strobe held, registers cleared ----
      clear_prog();
      emit(enc_s(20, 1, 0));                          // sw x1,20 with x1 cleared
      expect_store(32'd20, 32'd0);
      i_reset = 1'b0;
      @(negedge i_clk);
      check("reset_pc", {32'd0, o_pc}, {32'd0, 32'h0});
      check("reset_we", {63'd0, o_write_enable}, 64'd0);
      @(posedge i_clk);
      #2 i_reset = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      check("pc_after_first_clock", {32'd0, o_pc}, {32'd0, 32'h4});
      end_test("reset");

      // ---- reset asserted while a store is in flight ----
      clear_prog();
      emit(addi(1, 0, 9));
      emit(enc_s(56, 1, 0));
      saved   = dmem[14];
      i_reset = 1'b0;
      repeat (2) @(posedge i_clk);
      #2 i_reset = 1'b1;
      @(posedge i_clk);
      #1 i_reset = 1'b0;
      #1;
      check("midreset_pc", {32'd0, o_pc}, {32'd0, 32'h0});
      check("midreset_we", {63'd0, o_write_enable}, 64'd0);
      repeat (2) @(posedge i_clk);
      #1;
      check("midreset_no_write", {32'd0, dmem[14]}, {32'd0, saved});
      end_test("midreset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/processor.md
Name: processor

Overview:
- Single-cycle RV32I-subset CPU core.
- Connects to a word-addressed instruction memory with combinational read.
- Connects to a data memory with combinational read and write on the rising clock edge.
- Executes one instruction per clock; PC, register file and memory writes update on the same rising edge.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded while reset is asserted.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- o_pc  output  32  current instruction address; byte address, word aligned.
- i_instruction  input  32  instruction at o_pc, combinational from imem.
- o_write_enable  output  1  data memory write strobe; memory samples it on the rising edge.
- o_address_to_mem  output  32  data memory byte address, equal to the ALU result.
- o_data_to_mem  output  32  store data, equal to rs2 value.
- i_data_from_mem  input  32  combinational read data at o_address_to_mem.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - PC = RESET_PC; all 32 registers cleared to 0.
  - o_write_enable forced 0 while in reset.
  - First fetch happens at RESET_PC once reset is released.
- Register file:
  - 32x32, two combinational read ports, one write port on the rising edge.
  - x0 reads 0 and ignores writes.
  - A read of the register being written returns the old value (single cycle, no forwarding needed).
- Immediates are sign-extended per RISC-V I/S/B/U/J formats.
- Supported instructions:
  - R-type: add, sub, and, or, xor, slt (signed), sltu, sll, srl, sra. Shift amount is rs2[4:0].
  - I-type ALU: addi, andi, ori, xori, slti, sltiu, slli, srli, srai.
  - Memory: lw (rd <= i_data_from_mem), sw (o_write_enable=1, address = rs1+imm).
  - Branches: beq, bne, blt, bge, bltu, bgeu. Target = PC+immB.
  - Upper immediate: lui (rd <= immU), auipc (rd <= PC+immU).
  - Jumps:
    - jal: rd <= PC+4, PC <= PC+immJ.
    - jalr: rd <= PC+4, PC <= (rs1+immI) & ~1.
- Next PC:
  - Default PC+4.
  - Branch taken: PC+immB.
  - jal/jalr targets as above.
  - Wrap-around mod 2^32, no trap.
- Arithmetic: 32-bit modulo, overflow ignored.
- Loads and stores are word-only. Low address bits are passed unmodified; no alignment check.
- Any unsupported or illegal encoding executes as a NOP: no register write, no memory write, PC+4.
- When not storing, o_write_enable=0. o_address_to_mem and o_data_to_mem always reflect the current ALU result and rs2, so they may toggle freely.
- Reset asserted mid-execution: the in-flight instruction is discarded and no write occurs.

Optional Feature:
- Macro PROC_MUL_EN.
- Defined: supports mul (opcode 0110011, funct7 0000001, funct3 000). rd <= low 32 bits of rs1*rs2, combinational within the cycle.
- Undefined: that encoding is treated as unsupported and executes as a NOP (PC+4, no writes).

Test Plan:
- Reset:
  - Stimulus: hold i_reset=0, then release.
  - Required response: o_pc=0 and o_write_enable=0 during reset; o_pc=4 after the first clock.
- ALU:
  - Stimulus: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x2,x1; slt x5,x2,x1; sra x6,x2,x1 (shift by 5).
  - Required response: x3=2, x4=0xFFFF_FFF8, x5=1, x6=0xFFFF_FFFF; check by storing each to memory.
- Memory:
  - Stimulus: lui x7,0x12345; addi x7,x7,0x678; sw x7,8(x0); lw x8,8(x0); sw x8,12(x0).
  - Required response: o_write_enable=1, address 8, data 0x12345678; word 3 also becomes 0x12345678.
- Branches:
  - Stimulus: beq taken / not taken; blt with -1 < 1 (taken); bltu with 0xFFFFFFFF < 1 (not taken); loop that counts x1 to 10.
  - Required response: stored counter = 10; PC sequence matches the branch targets.
- Jumps and x0:
  - Stimulus: jal x1,+8 at PC 0x10; jalr x0,0(x1); addi x0,x0,7.
  - Required response: x1=0x14; PC goes 0x10 -> 0x18 -> 0x14; x0 stays 0.
- mul and illegal encoding:
  - Stimulus: mul with 7*-6; then an all-zero instruction word.
  - Required response: with PROC_MUL_EN, rd=0xFFFF_FFD6; without it, rd unchanged. The all-zero word is a NOP: PC+4, no writes.
